// File: rtl/log2_pipe_arbiter_if.sv
// Bundle of request, pipeline and response signals around the shared
// log2 pipeline arbiter. The arbiter takes the slave view; the
// environment (requesters, pipeline, consumers) takes the master view.
interface log2_pipe_arbiter_if #(
    parameter int DW = 16
);
    // requester side
    logic [1:0]      i_req_valid;
    logic [1:0]      o_req_ready;
    logic [2*DW-1:0] i_req_in0;
    logic [2*DW-1:0] i_req_in1;
    // shared pipeline side
    logic            o_pipe_en;
    logic            o_pipe_valid;
    logic [DW-1:0]   o_pipe_in0;
    logic [DW-1:0]   o_pipe_in1;
    logic            i_pipe_valid;
    logic [DW-1:0]   i_pipe_log2;
    logic [DW-1:0]   i_pipe_in0_byp;
    logic [DW-1:0]   i_pipe_in1_byp;
    // response side
    logic [1:0]      o_rsp_valid;
    logic [1:0]      i_rsp_ready;
    logic            o_rsp_err;
    logic [DW-1:0]   o_rsp_log2;
    logic [DW-1:0]   o_rsp_in0;
    logic [DW-1:0]   o_rsp_in1;
    logic            o_busy;

    modport slave (
        input  i_req_valid, i_req_in0, i_req_in1,
        input  i_pipe_valid, i_pipe_log2, i_pipe_in0_byp, i_pipe_in1_byp,
        input  i_rsp_ready,
        output o_req_ready,
        output o_pipe_en, o_pipe_valid, o_pipe_in0, o_pipe_in1,
        output o_rsp_valid, o_rsp_err, o_rsp_log2, o_rsp_in0, o_rsp_in1,
        output o_busy
    );

    modport master (
        output i_req_valid, i_req_in0, i_req_in1,
        output i_pipe_valid, i_pipe_log2, i_pipe_in0_byp, i_pipe_in1_byp,
        output i_rsp_ready,
        input  o_req_ready,
        input  o_pipe_en, o_pipe_valid, o_pipe_in0, o_pipe_in1,
        input  o_rsp_valid, o_rsp_err, o_rsp_log2, o_rsp_in0, o_rsp_in1,
        input  o_busy
    );
endinterface

// File: rtl/log2_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency log2 pipeline between two
// requesters. Each issued beat carries a {issued, id} tag through a shift
// register that advances with the pipeline; the tag at the far end lines up
// with the pipeline outputs and steers the response. A head beat whose
// consumer is not ready freezes the whole pipeline, tags included, so beats
// are never dropped or reordered.
module log2_pipe_arbiter #(
    parameter int LAT = 3,
    parameter int DW  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    log2_pipe_arbiter_if.slave     bus
);

    logic [LAT-1:0] issued_q, issued_d;
    logic [LAT-1:0] id_q, id_d;
    logic           ptr_q, ptr_d;

    logic           head_issued;
    logic           head_id;
    logic           stall;
    logic           pipe_en;
    logic           grant;
    logic           winner;

    // flow control and round-robin selection; reset forces the pipe idle
    always_comb begin
        head_issued = issued_q[LAT-1];
        head_id     = id_q[LAT-1];
        stall       = head_issued & ~bus.i_rsp_ready[head_id];
        pipe_en     = ~stall & ~i_rst;
        winner      = bus.i_req_valid[ptr_q] ? ptr_q : ~ptr_q;
        grant       = pipe_en & (|bus.i_req_valid);
        ptr_d       = grant ? ~winner : ptr_q;
    end

    // tag shift register: load the new tag and shift only on enabled cycles
    always_comb begin
        issued_d = issued_q;
        id_d     = id_q;
        if (pipe_en) begin
            issued_d[0] = grant;
            id_d[0]     = winner;
            for (int i = 1; i < LAT; i++) begin
                issued_d[i] = issued_q[i-1];
                id_d[i]     = id_q[i-1];
            end
        end
    end

    // state registers; in-flight beats are discarded on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issued_q <= '0;
            id_q     <= '0;
            ptr_q    <= 1'b0;
        end else begin
            issued_q <= issued_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
        end
    end

    // issue side: the winner's operands go to the pipeline, zero otherwise
    assign bus.o_pipe_en    = pipe_en;
    assign bus.o_pipe_valid = grant;
    assign bus.o_pipe_in0   = grant ? (winner ? bus.i_req_in0[2*DW-1:DW] : bus.i_req_in0[DW-1:0]) : '0;
    assign bus.o_pipe_in1   = grant ? (winner ? bus.i_req_in1[2*DW-1:DW] : bus.i_req_in1[DW-1:0]) : '0;

    // per-requester ready and response valid, decoded from winner / head id
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign bus.o_req_ready[gi] = grant & (winner == 1'(gi));
        assign bus.o_rsp_valid[gi] = head_issued & (head_id == 1'(gi));
    end

    // response data is a straight passthrough of the pipeline outputs
    assign bus.o_rsp_err  = head_issued & ~bus.i_pipe_valid;
    assign bus.o_rsp_log2 = bus.i_pipe_log2;
    assign bus.o_rsp_in0  = bus.i_pipe_in0_byp;
    assign bus.o_rsp_in1  = bus.i_pipe_in1_byp;
    assign bus.o_busy     = |issued_q;

endmodule

// File: tb/tb_log2_pipe_arbiter.sv
// Bench for log2_pipe_arbiter: a stand-in 3-stage log2 pipeline, directed
// scenarios with literal expectations, and a randomized phase. A queue of
// in-flight beats (each with its age in enabled cycles) predicts every
// DUT output on every cycle.
module tb_log2_pipe_arbiter;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    log2_pipe_arbiter_if #(.DW(DW)) bus();

    log2_pipe_arbiter #(.LAT(LAT), .DW(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Q6.10 log2 approximation: leading-one position plus linear mantissa
    function automatic logic [15:0] log2_approx(input logic [15:0] x);
        int p;
        logic [15:0] sh;
        if (x == 16'h0) return 16'h0;
        p = 0;
        for (int i = 0; i < 16; i++) if (x[i]) p = i;
        sh = x << (15 - p);
        return 16'((p - 10) * 1024) + {6'b0, sh[14:5]};
    endfunction

    // stand-in for the shared pipeline, reset with the arbiter
    logic [LAT-1:0] st_v;
    logic [DW-1:0]  st_a [LAT];
    logic [DW-1:0]  st_b [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                st_a[i] <= '0;
                st_b[i] <= '0;
            end
        end else if (bus.o_pipe_en) begin
            st_v    <= {st_v[LAT-2:0], bus.o_pipe_valid};
            st_a[0] <= bus.o_pipe_in0;
            st_b[0] <= bus.o_pipe_in1;
            for (int i = 1; i < LAT; i++) begin
                st_a[i] <= st_a[i-1];
                st_b[i] <= st_b[i-1];
            end
        end
    end
    assign bus.i_pipe_valid   = st_v[LAT-1] & ~st_a[LAT-1][15];
    assign bus.i_pipe_log2    = log2_approx(st_a[LAT-1]);
    assign bus.i_pipe_in0_byp = st_a[LAT-1];
    assign bus.i_pipe_in1_byp = st_b[LAT-1];

    // reference model: beats in issue order, age counted in enabled cycles
    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        int          age;
    } beat_t;
    beat_t fly[$];
    bit    m_ptr = 1'b0;
    int    grant_log[$];

    // compare every DUT output against the model each cycle, then advance it
    always @(negedge clk) begin : cmp
        bit          has_head, stall_m, en_m, g_m, w_m;
        logic [1:0]  exp_rv;
        logic [15:0] exp_in0, exp_in1;
        beat_t       nb;
        if (rst) begin
            fly.delete();
            m_ptr = 1'b0;
            check("rst_pipe_en", bus.o_pipe_en, 0);
            check("rst_req_ready", bus.o_req_ready, 0);
            check("rst_rsp_valid", bus.o_rsp_valid, 0);
            check("rst_busy", bus.o_busy, 0);
        end else begin
            has_head = (fly.size() > 0) && (fly[0].age == LAT - 1);
            stall_m  = has_head && !bus.i_rsp_ready[fly[0].id];
            en_m     = !stall_m;
            g_m      = en_m && (|bus.i_req_valid);
            w_m      = bus.i_req_valid[m_ptr] ? m_ptr : !m_ptr;
            exp_in0  = g_m ? (w_m ? bus.i_req_in0[31:16] : bus.i_req_in0[15:0]) : 16'h0;
            exp_in1  = g_m ? (w_m ? bus.i_req_in1[31:16] : bus.i_req_in1[15:0]) : 16'h0;
            exp_rv   = has_head ? (fly[0].id ? 2'b10 : 2'b01) : 2'b00;
            check("pipe_en", bus.o_pipe_en, en_m);
            check("req_ready", bus.o_req_ready, g_m ? (w_m ? 2'b10 : 2'b01) : 2'b00);
            check("pipe_valid", bus.o_pipe_valid, g_m);
            check("pipe_in0", bus.o_pipe_in0, exp_in0);
            check("pipe_in1", bus.o_pipe_in1, exp_in1);
            check("rsp_valid", bus.o_rsp_valid, exp_rv);
            check("busy", bus.o_busy, fly.size() > 0);
            if (has_head) begin
                check("rsp_err", bus.o_rsp_err, fly[0].a[15]);
                check("rsp_log2", bus.o_rsp_log2, log2_approx(fly[0].a));
                check("rsp_in0", bus.o_rsp_in0, fly[0].a);
                check("rsp_in1", bus.o_rsp_in1, fly[0].b);
            end
            if (en_m) begin
                if (has_head) void'(fly.pop_front());
                foreach (fly[i]) fly[i].age++;
                if (g_m) begin
                    nb.id  = w_m;
                    nb.a   = exp_in0;
                    nb.b   = exp_in1;
                    nb.age = 0;
                    fly.push_back(nb);
                    grant_log.push_back(int'(w_m));
                    m_ptr = !w_m;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one beat from requester k, return in the cycle after acceptance
    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok = 1'b0;
        tick();
        bus.i_req_valid[k] = 1'b1;
        bus.i_req_in0[k*16 +: 16] = a;
        bus.i_req_in1[k*16 +: 16] = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.o_req_ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        tick();
        bus.i_req_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b11;
        for (int n = 0; n < 20; n++) begin
            if (!bus.o_busy) break;
            tick();
        end
        check("drain_busy", bus.o_busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gl0;
        int rem [2];
        bit pend [2];

        rst = 1'b1;
        bus.i_req_valid = 2'b00;
        bus.i_req_in0   = '0;
        bus.i_req_in1   = '0;
        bus.i_rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single beat from requester 0: response exactly LAT cycles later
        send(0, 16'h1000, 16'h00AA);
        check("t1_early_rv", bus.o_rsp_valid, 2'b00);
        tick();
        check("t1_still_early", bus.o_rsp_valid, 2'b00);
        tick();
        check("t1_rsp_valid", bus.o_rsp_valid, 2'b01);
        check("t1_log2", bus.o_rsp_log2, 16'h0800);
        check("t1_in1", bus.o_rsp_in1, 16'h00AA);
        check("t1_err", bus.o_rsp_err, 0);

        // single beat from requester 1
        send(1, 16'h0400, 16'h1234);
        tick();
        tick();
        check("t2_rsp_valid", bus.o_rsp_valid, 2'b10);
        check("t2_log2", bus.o_rsp_log2, 16'h0000);
        check("t2_err", bus.o_rsp_err, 0);

        // negative operand returns flagged as error
        send(0, 16'h8000, 16'h0001);
        tick();
        tick();
        check("t3_rsp_valid", bus.o_rsp_valid, 2'b01);
        check("t3_err", bus.o_rsp_err, 1);
        drain();

        // both streaming 4 beats each after reset: strict alternation
        do_reset();
        gl0 = grant_log.size();
        rem[0] = 4;
        rem[1] = 4;
        for (int n = 0; n < 100 && (rem[0] + rem[1]) > 0; n++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                bus.i_req_valid[k] = rem[k] > 0;
                bus.i_req_in0[k*16 +: 16] = 16'(16'h0100 * (k + 1) + rem[k]);
                bus.i_req_in1[k*16 +: 16] = 16'(k * 16 + rem[k]);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (bus.i_req_valid[k] && bus.o_req_ready[k]) rem[k]--;
        end
        check("stream_done", rem[0] + rem[1], 0);
        tick();
        bus.i_req_valid = 2'b00;
        for (int i = 0; i < 8; i++)
            check($sformatf("stream_grant%0d", i),
                  (gl0 + i < grant_log.size()) ? grant_log[gl0 + i] : -1, i % 2);
        drain();

        // head stall on requester 0 for 5 cycles while requester 1 waits
        bus.i_rsp_ready = 2'b10;
        send(0, 16'h2000, 16'h0055);
        bus.i_req_valid[1] = 1'b1;
        bus.i_req_in0[31:16] = 16'h0800;
        bus.i_req_in1[31:16] = 16'h0066;
        tick();
        tick();
        for (int n = 0; n < 5; n++) begin
            check("stall_pipe_en", bus.o_pipe_en, 0);
            check("stall_req_ready", bus.o_req_ready, 2'b00);
            check("stall_rsp_valid", bus.o_rsp_valid, 2'b01);
            check("stall_log2", bus.o_rsp_log2, 16'h0C00);
            tick();
        end
        bus.i_rsp_ready = 2'b11;
        #1;
        check("release_pipe_en", bus.o_pipe_en, 1);
        check("release_req_ready", bus.o_req_ready, 2'b10);
        tick();
        bus.i_req_valid = 2'b00;
        check("after_stall_rv", bus.o_rsp_valid, 2'b10);
        check("after_stall_log2", bus.o_rsp_log2, 16'h0400);
        drain();

        // randomized traffic with random consumer back-pressure
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            tick();
            bus.i_rsp_ready[0] = ($urandom_range(0, 3) != 0);
            bus.i_rsp_ready[1] = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 2; k++) begin
                if (!pend[k]) begin
                    pend[k] = ($urandom_range(0, 9) < 6);
                    bus.i_req_in0[k*16 +: 16] = ($urandom_range(0, 7) == 0) ?
                        16'($urandom | 32'h8000) : 16'($urandom & 32'h7FFF);
                    bus.i_req_in1[k*16 +: 16] = 16'($urandom);
                end
                bus.i_req_valid[k] = pend[k];
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                if (bus.i_req_valid[k] && bus.o_req_ready[k]) pend[k] = 1'b0;
        end
        tick();
        drain();

        // async reset with two beats in flight: everything drops at once
        bus.i_rsp_ready = 2'b00;
        send(0, 16'h1000, 16'h0011);
        send(1, 16'h2000, 16'h0022);
        bus.i_req_valid[0] = 1'b1;
        check("pre_rst_busy", bus.o_busy, 1);
        check("pre_rst_rv", bus.o_rsp_valid, 2'b01);
        tick();
        rst = 1'b1;
        #1;
        check("rst_now_rv", bus.o_rsp_valid, 2'b00);
        check("rst_now_busy", bus.o_busy, 0);
        check("rst_now_ready", bus.o_req_ready, 2'b00);
        check("rst_now_en", bus.o_pipe_en, 0);
        tick();
        tick();
        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b11;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("post_rst_rv", bus.o_rsp_valid, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
